pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W SHALL default to 64 and set the payload width, e.g. {pc, inst}.
REQ-002 Parameter BUBBLE_VAL SHALL default to all-zeros (DATA_W bits) and set the value driven on out_data when the stage is empty or flushed.
REQ-003 Parameter CNT_W SHALL default to 16 and set the width of kill_cnt.
REQ-004 Port clk SHALL be an input, 1 bit: clock; all state changes on rising edge.
REQ-005 Port reset SHALL be an input, 1 bit: reset, synchronous, active-high.
REQ-006 Port in_valid SHALL be an input, 1 bit: upstream payload valid.
REQ-007 Port in_ready SHALL be an output, 1 bit: stage can accept this cycle.
REQ-008 Port in_data SHALL be an input, DATA_W bits: upstream payload.
REQ-009 Port out_valid SHALL be an output, 1 bit: head entry valid.
REQ-010 Port out_ready SHALL be an input, 1 bit: downstream accepts.
REQ-011 Port out_data SHALL be an output, DATA_W bits, registered: head entry payload.
REQ-012 Port flush SHALL be an input, 1 bit: kill all held entries (branch taken).
REQ-013 Port hold SHALL be an input, 1 bit: freeze stage (external stall).
REQ-014 Port occupancy SHALL be an output, 2 bits: number of valid entries (0..2).
REQ-015 Port kill_cnt SHALL be an output, CNT_W bits: count of valid entries discarded by flush.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 The state machine SHALL have states EMPTY (0 entries), FULL (main entry), and SKID (main + skid entry; only with the macro).
REQ-018 Transitions SHALL be: EMPTY + in -> FULL; FULL + out only -> EMPTY; FULL + in + out -> FULL with main replaced; FULL + in only -> SKID; SKID + out -> FULL with skid moved to main; all other cases stay.
REQ-019 Latency SHALL be one cycle: data accepted at edge N appears on out_data with out_valid=1 after edge N.
REQ-020 Entries SHALL leave in acceptance order; no duplication or loss except by flush.
REQ-021 out_valid SHALL be 1 iff the state is not EMPTY and hold=0.
REQ-022 out_data SHALL equal BUBBLE_VAL whenever the state is EMPTY.
REQ-023 While hold=1: in_ready=0, out_valid=0, and state/data unchanged.
REQ-024 flush SHALL take priority over hold and transfers: next state EMPTY, out_data=BUBBLE_VAL, and any same-cycle input is dropped.
REQ-025 On flush, kill_cnt SHALL add the current occupancy (0, 1, or 2), saturating at all-ones with no wrap.
REQ-026 occupancy SHALL read 0/1/2 for EMPTY/FULL/SKID.

Reset
REQ-027 Reset SHALL have priority over flush and hold.
REQ-028 On reset: state EMPTY, out_valid=0, out_data=BUBBLE_VAL, skid entry cleared, occupancy=0, kill_cnt=0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries without incrementing kill_cnt.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN, when defined, SHALL compile in the skid entry and SKID state, with in_ready = (state != SKID) && !hold driven from a register.
REQ-031 Without PIPE_STAGE_SKID_EN: one entry, SKID unreachable, in_ready = (!out_valid || out_ready) && !hold (combinational), and occupancy never exceeds 1.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the state enum (EMPTY/FULL/SKID) and the default bubble constant.
REQ-033 The design SHALL be a single module with no sub-module; the skid entry is inline under the macro.

Verification
REQ-034 Reset, then in_data=0x11 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_data=0x11, occupancy=1.
REQ-035 (skid) out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB in order.
REQ-036 Occupancy=2, flush=1 with in_valid=1 -> next cycle EMPTY, out_data=0, kill_cnt +2, input dropped.
REQ-037 hold=1 for 3 cycles while FULL with 0x55 -> out_valid=0, in_ready=0; release -> out_data=0x55 unchanged.
REQ-038 CNT_W=2, four flushes at occupancy=1 -> kill_cnt saturates at 3.
REQ-039 Reset and flush asserted together while FULL -> EMPTY, kill_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared state encoding and bubble default for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   // Bubble payload is this bit replicated across the full data width.
   localparam logic c_bubble_bit = 1'b0;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : One-cycle pipeline stage register with flush, hold, kill
//               counter and optional skid entry (macro PIPE_STAGE_SKID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W     = 64,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{c_bubble_bit}},
   parameter int                 CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              hold,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  kill_cnt
);

   state_t            r_state;
   logic [DATA_W-1:0] r_main;
   logic [CNT_W-1:0]  r_kill;
   logic [CNT_W:0]    w_kill_sum;
   logic [1:0]        w_occ;
   logic              w_in_xfer;
   logic              w_out_xfer;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_W-1:0] r_skid;
   logic              r_can_accept;

   assign in_ready = r_can_accept && !hold;
`else
   assign in_ready = (!out_valid || out_ready) && !hold;
`endif

   assign out_valid  = (r_state != EMPTY) && !hold;
   assign out_data   = r_main;
   assign occupancy  = w_occ;
   assign kill_cnt   = r_kill;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   always_comb begin
      w_occ = 2'd0;
      case (r_state)
         EMPTY:   w_occ = 2'd0;
         FULL:    w_occ = 2'd1;
         default: w_occ = 2'd2;
      endcase
   end

   // One extra bit catches the carry so the counter sticks at all-ones.
   assign w_kill_sum = {1'b0, r_kill} + (CNT_W+1)'(w_occ);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_main  <= BUBBLE_VAL;
         r_kill  <= '0;
`ifdef PIPE_STAGE_SKID_EN
         r_skid       <= BUBBLE_VAL;
         r_can_accept <= 1'b1;
`endif
      end else if (flush) begin
         r_state <= EMPTY;
         r_main  <= BUBBLE_VAL;
         r_kill  <= w_kill_sum[CNT_W] ? {CNT_W{1'b1}} : w_kill_sum[CNT_W-1:0];
`ifdef PIPE_STAGE_SKID_EN
         r_skid       <= BUBBLE_VAL;
         r_can_accept <= 1'b1;
`endif
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  r_main  <= in_data;
                  r_state <= FULL;
               end
            end
            FULL: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_main <= in_data;
               end else if (w_out_xfer) begin
                  r_main  <= BUBBLE_VAL;
                  r_state <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
               end else if (w_in_xfer) begin
                  r_skid       <= in_data;
                  r_state      <= SKID;
                  r_can_accept <= 1'b0;
`endif
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            SKID: begin
               if (w_out_xfer) begin
                  r_main       <= r_skid;
                  r_skid       <= BUBBLE_VAL;
                  r_state      <= FULL;
                  r_can_accept <= 1'b1;
               end
            end
`endif
            default: r_state <= r_state;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Directed + random scoreboard bench for pipe_stage_reg (CNT_W=2 so the
// kill counter saturation is reachable).
module tb_pipe_stage_reg;

   localparam int          DATA_W = 64;
   localparam int          CNT_W  = 2;
   localparam logic [63:0] BUBBLE = 64'h0;
`ifdef PIPE_STAGE_SKID_EN
   localparam int          DEPTH  = 2;
`else
   localparam int          DEPTH  = 1;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              flush = 1'b0;
   logic              hold = 1'b0;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  kill_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] q[$];
   int          exp_kill = 0;

   pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .flush(flush), .hold(hold),
      .occupancy(occupancy), .kill_cnt(kill_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock of stimulus; the queue q is the reference model of held entries.
   task automatic step(input logic v, input logic [63:0] d, input logic ordy,
                       input logic fl, input logic hd, input logic rs);
      logic exp_rdy, exp_ov;
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = ordy; flush = fl; hold = hd; reset = rs;
      #1;
      exp_ov  = (q.size() > 0) && !hd;
      exp_rdy = !hd && ((DEPTH == 2) ? (q.size() < 2) : (q.size() == 0 || ordy));
      if (!rs) begin
         chk("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
         chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
         if (exp_ov) chk("out_data_head", out_data, q[0]);
      end
      @(posedge clk);
      if (rs) begin
         q.delete();
         exp_kill = 0;
      end else if (fl) begin
         exp_kill = exp_kill + q.size();
         if (exp_kill > 3) exp_kill = 3;
         q.delete();
      end else begin
         if (exp_ov && ordy) void'(q.pop_front());
         if (v && exp_rdy) q.push_back(d);
      end
      #1;
      chk("occupancy", {62'b0, occupancy}, 64'(q.size()));
      chk("kill_cnt", {62'b0, kill_cnt}, 64'(exp_kill));
      chk("out_data_reg", out_data, (q.size() > 0) ? q[0] : BUBBLE);
   endtask

   initial begin
      // reset state
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      // single push, then replace, then drain
      step(1, 64'h11, 1, 0, 0, 0);
      step(1, 64'h22, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      // hold for 3 cycles while full
      step(1, 64'h55, 0, 0, 0, 0);
      repeat (3) step(1, 64'h99, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      // flush while full drops the same-cycle input; four flushes saturate
      repeat (4) begin
         step(1, 64'h77, 0, 1, 0, 0);
         step(1, 64'h66, 0, 0, 0, 0);
      end
      step(1, 64'h44, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      // reset and flush together while full
      step(1, 64'h33, 0, 0, 0, 0);
      step(1, 64'h88, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      // two-entry fill, flush, refill and ordered drain
      step(1, 64'hA, 0, 0, 0, 0);
      step(1, 64'hB, 0, 0, 0, 0);
      step(1, 64'hC, 0, 0, 0, 0);
      step(1, 64'hD, 0, 1, 0, 0);
      step(1, 64'hA, 0, 0, 0, 0);
      step(1, 64'hB, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      // random traffic against the model
      for (int i = 0; i < 80; i++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0), 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
